// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: groups the MEM-stage, CP0 and redirect signals of the
// exception controller.
//   slave  : the exc_ctrl side (i_* in, o_* out)
//   master : the pipeline/CP0 side driving i_* and observing o_*
interface exc_ctrl_if;
  logic [5:0]  i_hw_int;
  logic        i_timer_int;
  logic        i_mem_valid;
  logic        i_mem_stall;
  logic [31:0] i_mem_pc;
  logic        i_mem_in_delay_slot;
  logic [4:0]  i_mem_exc_cause;
  logic        i_mem_is_eret;
  logic [31:0] i_status;
  logic [31:0] i_epc;

  logic [5:0]  o_int;
  logic [4:0]  o_except_cause;
  logic [31:0] o_current_pc;
  logic        o_is_in_delay_slot;
  logic        o_is_eret;
  logic        o_flush;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_busy;

  modport slave (
    input  i_hw_int, i_timer_int, i_mem_valid, i_mem_stall, i_mem_pc,
           i_mem_in_delay_slot, i_mem_exc_cause, i_mem_is_eret, i_status, i_epc,
    output o_int, o_except_cause, o_current_pc, o_is_in_delay_slot, o_is_eret,
           o_flush, o_redirect_valid, o_redirect_pc, o_busy
  );

  modport master (
    output i_hw_int, i_timer_int, i_mem_valid, i_mem_stall, i_mem_pc,
           i_mem_in_delay_slot, i_mem_exc_cause, i_mem_is_eret, i_status, i_epc,
    input  o_int, o_except_cause, o_current_pc, o_is_in_delay_slot, o_is_eret,
           o_flush, o_redirect_valid, o_redirect_pc, o_busy
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt/ERET sequencer sitting at the MEM stage.
// Accepts one event, reports it to CP0 for a single cycle, flushes the
// pipeline for FLUSH_CYCLES further cycles, then issues a one-cycle PC
// redirect to the exception vector (or to EPC for ERET).
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : exc_ctrl_if.slave (MEM-stage inputs, CP0 status/EPC,
//            synchronized interrupts, CP0 capture fields, flush/redirect)
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting; an accepted event is reported combinationally here
// S_FLUSH    | pipeline flush, down-counter runs to terminal count 1
// S_REDIRECT | one-cycle redirect strobe with latched target
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input logic       clk,
  input logic       resetn,
  exc_ctrl_if.slave bus
);

  localparam logic [4:0] EXC_CAUSE_INT = 5'h00;
  localparam logic [4:0] EXC_CAUSE_NOP = 5'h1F;
  localparam logic [3:0] FLUSH_LOAD    = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic [5:0]  sync1_q, sync2_q;

  logic        int_req;
  logic        has_cause;
  logic        accept;
  logic        unused_status;

  // Only IE, EXL and IM are consulted.
  assign unused_status = ^{bus.i_status[31:16], bus.i_status[9:2]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'd0;
      sync1_q  <= 6'd0;
      sync2_q  <= 6'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sync1_q  <= bus.i_hw_int;
      sync2_q  <= sync1_q;
    end
  end

  // Timer is already in the clk domain, so it bypasses the synchronizer.
  assign bus.o_int = {sync2_q[5] | bus.i_timer_int, sync2_q[4:0]};

  assign int_req   = (|(bus.o_int & bus.i_status[15:10])) & bus.i_status[0] & ~bus.i_status[1];
  assign has_cause = (bus.i_mem_exc_cause != EXC_CAUSE_NOP);
  assign accept    = bus.i_mem_valid & ~bus.i_mem_stall & (int_req | has_cause | bus.i_mem_is_eret);

  assign bus.o_busy = (state_q != S_IDLE);

  always_comb begin
    state_d                = state_q;
    cnt_d                  = cnt_q;
    target_d               = target_q;
    bus.o_except_cause     = EXC_CAUSE_NOP;
    bus.o_current_pc       = 32'd0;
    bus.o_is_in_delay_slot = 1'b0;
    bus.o_is_eret          = 1'b0;
    bus.o_flush            = 1'b0;
    bus.o_redirect_valid   = 1'b0;
    bus.o_redirect_pc      = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          bus.o_flush            = 1'b1;
          bus.o_current_pc       = bus.i_mem_pc;
          bus.o_is_in_delay_slot = bus.i_mem_in_delay_slot;
          state_d                = S_FLUSH;
          cnt_d                  = FLUSH_LOAD;
          if (int_req) begin
            bus.o_except_cause = EXC_CAUSE_INT;
            target_d           = EXC_VECTOR;
          end else if (has_cause) begin
            bus.o_except_cause = bus.i_mem_exc_cause;
            target_d           = EXC_VECTOR;
          end else begin
            bus.o_is_eret = 1'b1;
            target_d      = bus.i_epc;
          end
        end
      end

      S_FLUSH: begin
        bus.o_flush = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        // <= guards against a stray zero count locking the FSM in FLUSH.
        if (cnt_q <= 4'd1) begin
          state_d = S_REDIRECT;
          cnt_d   = 4'd0;
        end
      end

      S_REDIRECT: begin
        bus.o_redirect_valid = 1'b1;
        bus.o_redirect_pc    = target_q;
        state_d              = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

endmodule
